// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage buffer.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int DW_MAX = 256;

    // Widest possible clear value; users slice it down to their payload width.
    localparam logic [DW_MAX-1:0] CLR_VAL_DEFAULT = '0;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready channel carrying an opaque DW-bit payload.
interface pipe_stage_buf_if #(
    parameter int DW = 64
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One payload register: synchronous reset and clear both load CLR_VAL; clear beats load.
module pipe_slot #(
    parameter int            DW      = 64,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= CLR_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage with optional skid entry and synchronous flush.
// out_data always comes from the main slot; the skid slot only refills it.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int            DW      = 64,
    parameter bit            SKID    = 1'b1,
    parameter logic [DW-1:0] CLR_VAL = CLR_VAL_DEFAULT[DW-1:0]
) (
    input  logic             i_clk,
    input  logic             i_rst,
    pipe_stage_buf_if.slave  i_up,
    pipe_stage_buf_if.master o_dn,
    input  logic             i_flush,
    input  logic             i_hold,
    output logic [1:0]       o_occ
);

    state_t        r_state;
    logic          r_out_valid;
    logic          r_in_ready;
    logic [1:0]    r_occ;

    logic          w_take;
    logic          w_accept;
    logic          w_in_ready;
    logic          w_main_load;
    logic          w_skid_load;
    logic [DW-1:0] w_main_d;
    logic [DW-1:0] w_main_q;
    logic [DW-1:0] w_skid_q;

    always_comb begin
        w_take      = r_out_valid & o_dn.ready & ~i_hold;
        w_accept    = i_up.valid & w_in_ready & ~i_flush;
        // Main refills from skid when draining SKIDDED, otherwise from the producer.
        w_main_load = (w_accept & ((r_state == ST_EMPTY) | w_take))
                    | ((r_state == ST_SKID) & w_take);
        w_skid_load = w_accept & (r_state == ST_FULL) & ~w_take;
        w_main_d    = (r_state == ST_SKID) ? w_skid_q : i_up.data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (SKID && w_accept && !w_take) begin
                        r_state     <= ST_SKID;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd2;
                        r_in_ready  <= 1'b0;
                    end else if (!w_accept && w_take) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_occ       <= 2'd0;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_SKID: begin
                    if (w_take) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd1;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_occ       <= 2'd0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(
        .DW      (DW),
        .CLR_VAL (CLR_VAL)
    ) u_main (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_flush),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(
                .DW      (DW),
                .CLR_VAL (CLR_VAL)
            ) u_skid (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_clr  (i_flush),
                .i_load (w_skid_load),
                .i_d    (i_up.data),
                .o_q    (w_skid_q)
            );
            assign w_in_ready = r_in_ready;
        end else begin : g_noskid
            // Without a skid entry the stage can only accept when the word it holds leaves.
            assign w_skid_q   = CLR_VAL;
            assign w_in_ready = ~r_out_valid | (o_dn.ready & ~i_hold);
        end
    endgenerate

    assign i_up.ready = w_in_ready;
    assign o_dn.valid = r_out_valid;
    assign o_dn.data  = w_main_q;
    assign o_occ      = r_occ;

endmodule
